// File: rtl/valu_vec_seq.sv
// valu_vec_seq: runs the combinational VALU over a vector of L packed words (4 x int8 lanes)
// taken from an operand stream.
//   VSUM/VSUB : one registered result word per operand word (1-deep output slice).
//   VDP       : per-word dot products accumulated into one 32-bit signed result.
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   start_i, op_i, len_i         job request (sampled only in IDLE)
//   busy_o, done_o, err_o        job status; err_o valid with done_o
//   in_valid_i/in_ready_o        operand handshake, in_a_i/in_b_i operand words
//   out_valid_o/out_ready_i      result handshake, out_data_o/out_over_o result
//   acc_ovf_o                    sticky VDP accumulator signed overflow
//   valu_v1_o/valu_v2_o/valu_ctrl_o  drive the VALU; valu_v_i/valu_over_i its outputs
module valu_vec_seq #(
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      in_a_i,
    input  logic [31:0]      in_b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      out_data_o,
    output logic [3:0]       out_over_o,
    output logic             acc_ovf_o,
    output logic [31:0]      valu_v1_o,
    output logic [31:0]      valu_v2_o,
    output logic [2:0]       valu_ctrl_o,
    input  logic [31:0]      valu_v_i,
    input  logic [3:0]       valu_over_i
);

    localparam logic [2:0] OpVsum = 3'b010;
    localparam logic [2:0] OpVsub = 3'b110;
    localparam logic [2:0] OpVdp  = 3'b001;
    localparam logic [2:0] OpPass = 3'b011;

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [2:0]       r_op;
    logic [LEN_W-1:0] r_rem;
    logic [31:0]      r_acc;
    logic             r_acc_ovf;
    logic             r_err;
    logic             r_out_valid;
    logic [31:0]      r_out_data;
    logic [3:0]       r_out_over;

    logic        w_op_legal;
    logic        w_is_vdp;
    logic        w_in_ready;
    logic        w_in_fire;
    logic        w_out_fire;
    logic        w_last;
    logic [31:0] w_acc_sum;
    logic        w_sum_ovf;

    always_comb begin
        w_op_legal = (op_i == OpVsum) || (op_i == OpVsub) || (op_i == OpVdp);
        w_is_vdp   = (r_op == OpVdp);
        // VDP never holds a result in RUN, so the input is always open there.
        w_in_ready = (r_state == StRun) && (w_is_vdp || !r_out_valid || out_ready_i);
        w_in_fire  = in_valid_i && w_in_ready;
        w_out_fire = r_out_valid && out_ready_i;
        w_last     = (r_rem == LEN_W'(1));
        w_acc_sum  = r_acc + valu_v_i;
        w_sum_ovf  = (r_acc[31] == valu_v_i[31]) && (w_acc_sum[31] != r_acc[31]);
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (start_i) begin
                    if (!w_op_legal || (len_i == '0)) w_state_next = StDone;
                    else                              w_state_next = StRun;
                end
            end
            StRun:   if (w_in_fire && w_last) w_state_next = StFlush;
            StFlush: if (w_out_fire) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= StIdle;
            r_op        <= OpPass;
            r_rem       <= '0;
            r_acc       <= '0;
            r_acc_ovf   <= 1'b0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_over  <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                StIdle: begin
                    if (start_i) begin
                        r_op      <= op_i;
                        r_rem     <= len_i;
                        r_acc     <= '0;
                        r_acc_ovf <= 1'b0;
                        r_err     <= !w_op_legal;
                    end
                end
                StRun: begin
                    if (w_in_fire) r_rem <= r_rem - LEN_W'(1);
                    if (w_is_vdp) begin
                        if (w_in_fire) begin
                            r_acc <= w_acc_sum;
                            if (w_sum_ovf) r_acc_ovf <= 1'b1;
                            // Final sum goes straight to the output register on the last word.
                            if (w_last) begin
                                r_out_valid <= 1'b1;
                                r_out_data  <= w_acc_sum;
                                r_out_over  <= '0;
                            end
                        end
                    end else if (w_in_fire) begin
                        // Covers the simultaneous drain+reload case: valid stays high.
                        r_out_valid <= 1'b1;
                        r_out_data  <= valu_v_i;
                        r_out_over  <= valu_over_i;
                    end else if (w_out_fire) begin
                        r_out_valid <= 1'b0;
                    end
                end
                StFlush: if (w_out_fire) r_out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign busy_o      = (r_state == StRun) || (r_state == StFlush);
    assign done_o      = (r_state == StDone);
    assign err_o       = (r_state == StDone) && r_err;
    assign in_ready_o  = w_in_ready;
    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_data;
    assign out_over_o  = r_out_over;
    assign acc_ovf_o   = r_acc_ovf;
    assign valu_v1_o   = in_a_i;
    assign valu_v2_o   = in_b_i;
    assign valu_ctrl_o = (r_state == StIdle) ? OpPass : r_op;

endmodule

// File: tb/tb_valu_vec_seq.sv
module tb_valu_vec_seq;

    localparam int unsigned LW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [2:0]    op_i;
    logic [LW-1:0] len_i;
    logic          busy_o, done_o, err_o;
    logic          in_valid_i, in_ready_o;
    logic [31:0]   in_a_i, in_b_i;
    logic          out_valid_o, out_ready_i;
    logic [31:0]   out_data_o;
    logic [3:0]    out_over_o;
    logic          acc_ovf_o;
    logic [31:0]   valu_v1_o, valu_v2_o, valu_v_i;
    logic [2:0]    valu_ctrl_o;
    logic [3:0]    valu_over_i;

    int n_pass  = 0;
    int n_total = 0;
    logic [35:0] exp_q[$];

    valu_vec_seq #(.LEN_W(LW)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start_i), .op_i(op_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_a_i(in_a_i), .in_b_i(in_b_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .out_over_o(out_over_o), .acc_ovf_o(acc_ovf_o),
        .valu_v1_o(valu_v1_o), .valu_v2_o(valu_v2_o), .valu_ctrl_o(valu_ctrl_o),
        .valu_v_i(valu_v_i), .valu_over_i(valu_over_i)
    );

    always #5 clk = ~clk;

    // Stand-in VALU: lane add/sub with a per-lane "in range" flag, VDP = signed 4-lane dot product.
    function automatic logic [35:0] valu_model(input logic [2:0] ctrl, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [31:0] v;
        logic [3:0]  ov;
        logic signed [31:0] acc;
        logic signed [7:0]  sa, sb, r;
        logic signed [15:0] xa, xb, p;
        v = a; ov = 4'b0; acc = 0;
        for (int i = 0; i < 4; i++) begin
            sa = a[8*i +: 8];
            sb = b[8*i +: 8];
            xa = sa; xb = sb; p = xa * xb;
            if (ctrl == 3'b010) begin
                r = sa + sb; v[8*i +: 8] = r;
                ov[i] = !((sa[7] == sb[7]) && (r[7] != sa[7]));
            end else if (ctrl == 3'b110) begin
                r = sa - sb; v[8*i +: 8] = r;
                ov[i] = !((sa[7] != sb[7]) && (r[7] != sa[7]));
            end
            acc = acc + {{16{p[15]}}, p};
        end
        if (ctrl == 3'b001) v = acc;
        return {ov, v};
    endfunction

    assign {valu_over_i, valu_v_i} = valu_model(valu_ctrl_o, valu_v1_o, valu_v2_o);

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Scoreboard: every output handshake pops the oldest expected result.
    always @(negedge clk) begin
        if (!rst && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) chk("out_unexpected", 36'(exp_q.size()), 36'd1);
            else                   chk("out_word", {out_over_o, out_data_o}, exp_q.pop_front());
        end
    end

    // All tasks enter and leave just after a rising edge.
    task automatic start_job(input logic [2:0] op, input logic [LW-1:0] len);
        start_i = 1'b1; op_i = op; len_i = len;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic send(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input logic [35:0] exp);
        logic ok;
        ok = 1'b0;
        in_a_i = a; in_b_i = b; in_valid_i = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (in_ready_o) begin
                ok = 1'b1;
                if (push) exp_q.push_back(exp);
            end
        end
        chk({tag, "_accept"}, 36'(ok), 36'd1);
        @(posedge clk); #1;
        in_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic exp_err, output logic saw_out,
                             output logic saw_rdy);
        logic seen;
        seen = 1'b0; saw_out = 1'b0; saw_rdy = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (out_valid_o) saw_out = 1'b1;
            if (in_ready_o)  saw_rdy = 1'b1;
            if (done_o) begin
                seen = 1'b1;
                chk({tag, "_err"}, 36'(err_o), 36'(exp_err));
                chk({tag, "_busy_in_done"}, 36'(busy_o), 36'd0);
            end
        end
        chk({tag, "_done_seen"}, 36'(seen), 36'd1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 36'(done_o), 36'd0);
        @(posedge clk); #1;
    endtask

    logic so, sr, dseen;
    int   cnt;
    logic [35:0] e1, e2;

    initial begin
        rst = 1'b1; start_i = 1'b0; op_i = 3'b0; len_i = '0;
        in_valid_i = 1'b0; in_a_i = '0; in_b_i = '0; out_ready_i = 1'b1;
        @(negedge clk);
        chk("rst_busy", 36'(busy_o), 36'd0);
        chk("rst_done", 36'(done_o), 36'd0);
        chk("rst_err", 36'(err_o), 36'd0);
        chk("rst_out_valid", 36'(out_valid_o), 36'd0);
        chk("rst_in_ready", 36'(in_ready_o), 36'd0);
        chk("rst_out_data", 36'({out_over_o, out_data_o}), 36'd0);
        chk("rst_acc_ovf", 36'(acc_ovf_o), 36'd0);
        chk("rst_ctrl", 36'(valu_ctrl_o), 36'h3);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // VSUM L=1; done one cycle after the output handshake
        start_job(3'b010, 1);
        send("vsum", 32'h01020304, 32'h01010101, 1'b1, {4'b1111, 32'h02030405});
        @(negedge clk);
        chk("vsum_out_valid", 36'(out_valid_o), 36'd1);
        @(negedge clk);
        chk("vsum_done_after_hs", 36'(done_o), 36'd1);
        chk("vsum_err", 36'(err_o), 36'd0);
        @(negedge clk);
        chk("vsum_done_1cyc", 36'(done_o), 36'd0);
        @(posedge clk); #1;

        // VSUB L=2 under output backpressure
        e1 = valu_model(3'b110, 32'h80057F10, 32'h0103FF20);
        e2 = valu_model(3'b110, 32'h00000000, 32'h80808080);
        start_job(3'b110, 2);
        out_ready_i = 1'b0;
        send("vsub_w1", 32'h80057F10, 32'h0103FF20, 1'b1, e1);
        in_a_i = 32'h00000000; in_b_i = 32'h80808080; in_valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("vsub_stall_in_ready", 36'(in_ready_o), 36'd0);
            chk("vsub_stall_hold", {out_over_o, out_data_o}, e1);
        end
        @(posedge clk); #1;
        out_ready_i = 1'b1;
        send("vsub_w2", 32'h00000000, 32'h80808080, 1'b1, e2);
        wait_done("vsub", 1'b0, so, sr);
        chk("vsub_drained", 36'(exp_q.size()), 36'd0);

        // VDP L=2
        start_job(3'b001, 2);
        exp_q.push_back({4'b0, 32'h00000010});
        send("vdp_w1", 32'h01010101, 32'h02020202, 1'b0, 36'd0);
        @(negedge clk);
        chk("vdp_run_no_out", 36'(out_valid_o), 36'd0);
        @(posedge clk); #1;
        send("vdp_w2", 32'h01010101, 32'h02020202, 1'b0, 36'd0);
        wait_done("vdp", 1'b0, so, sr);
        chk("vdp_acc_ovf", 36'(acc_ovf_o), 36'd0);
        chk("vdp_drained", 36'(exp_q.size()), 36'd0);

        // Illegal op: no handshakes, error completion
        in_valid_i = 1'b1; in_a_i = 32'h11111111; in_b_i = 32'h22222222;
        start_job(3'b100, 5);
        wait_done("illegal", 1'b1, so, sr);
        in_valid_i = 1'b0;
        chk("illegal_no_out", 36'(so), 36'd0);
        chk("illegal_no_ready", 36'(sr), 36'd0);
        @(negedge clk);
        chk("idle_ctrl", 36'(valu_ctrl_o), 36'h3);
        @(posedge clk); #1;

        // L=0 VSUM
        start_job(3'b010, 0);
        wait_done("len0", 1'b0, so, sr);
        chk("len0_no_out", 36'(so), 36'd0);

        // Reset mid-RUN aborts silently
        start_job(3'b010, 3);
        out_ready_i = 1'b0;
        send("rst_w1", 32'h01010101, 32'h01010101, 1'b1, valu_model(3'b010, 32'h01010101, 32'h01010101));
        @(negedge clk);
        chk("midrun_valid", 36'(out_valid_o), 36'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrun_rst_busy", 36'(busy_o), 36'd0);
        chk("midrun_rst_out_valid", 36'(out_valid_o), 36'd0);
        chk("midrun_rst_out_data", 36'({out_over_o, out_data_o}), 36'd0);
        chk("midrun_rst_ctrl", 36'(valu_ctrl_o), 36'h3);
        @(posedge clk); #1;
        rst = 1'b0; exp_q.delete(); out_ready_i = 1'b1;
        dseen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done_o || busy_o) dseen = 1'b1;
        end
        chk("midrun_no_done", 36'(dseen), 36'd0);
        @(posedge clk); #1;

        // VDP L=32768 of 0x80808080: wraps to 0x80000000 with signed overflow
        start_job(3'b001, 16'd32768);
        exp_q.push_back({4'b0, 32'h80000000});
        in_a_i = 32'h80808080; in_b_i = 32'h80808080; in_valid_i = 1'b1;
        cnt = 0;
        for (int k = 0; k < 40000 && cnt < 32768; k++) begin
            @(negedge clk);
            if (in_ready_o) cnt++;
        end
        chk("big_accepts", 36'(cnt), 36'd32768);
        @(posedge clk); #1;
        @(negedge clk);
        chk("big_no_extra_accept", 36'(in_ready_o), 36'd0);
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        wait_done("big", 1'b0, so, sr);
        chk("big_acc_ovf", 36'(acc_ovf_o), 36'd1);
        chk("big_drained", 36'(exp_q.size()), 36'd0);
        @(negedge clk);
        chk("big_ovf_sticky", 36'(acc_ovf_o), 36'd1);
        @(posedge clk); #1;
        start_job(3'b010, 0);
        @(negedge clk);
        chk("ovf_cleared_on_start", 36'(acc_ovf_o), 36'd0);
        @(posedge clk); #1;
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
